// File: rtl/mult_32x32_fast.sv
// mult_32x32_fast
//   Sequential unsigned 32x32 -> 64-bit multiplier built on one shared 16x16
//   multiplier. One partial product is accumulated per clock. Partial products
//   whose operand upper half is zero are skipped, so an operation takes 4, 2 or
//   1 busy cycles depending on the upper halves of the latched operands.
//
// Ports
//   clk      in   1   rising-edge clock
//   reset    in   1   synchronous active-high reset; aborts any operation
//   start    in   1   request; accepted only while idle
//   a, b     in   32  unsigned operands, latched when start is accepted
//   busy     out  1   high while an operation is in progress
//   product  out  64  accumulator; holds the final result once busy is low
module mult_32x32_fast (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [63:0] product
);

    typedef enum logic [2:0] {
        IDLE,
        S00,
        S10,
        S01,
        S11
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] a_lat;
    logic [31:0] b_lat;
    logic [15:0] mul_x;
    logic [15:0] mul_y;
    logic [31:0] pp;
    logic [63:0] addend;
    logic        za;
    logic        zb;

    assign za   = (a_lat[31:16] == 16'd0);
    assign zb   = (b_lat[31:16] == 16'd0);
    assign busy = (state != IDLE);

    // Operands are pre-extended so the single multiplier yields a full 32-bit result.
    assign pp = {16'd0, mul_x} * {16'd0, mul_y};

    // Next state: walk S00 -> S10 -> S01 -> S11, skipping steps whose partial
    // product is known to be zero. Inside S10 za is false, inside S01 zb is false.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    state_next = start ? S00 : IDLE;
            S00: begin
                if (!za)
                    state_next = S10;
                else if (!zb)
                    state_next = S01;
                else
                    state_next = IDLE;
            end
            S10:     state_next = zb ? IDLE : S01;
            S01:     state_next = za ? IDLE : S11;
            S11:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Per-state operand mux into the shared multiplier and alignment of its result.
    always_comb begin
        mul_x  = '0;
        mul_y  = '0;
        addend = '0;
        unique case (state)
            S00: begin
                mul_x  = a_lat[15:0];
                mul_y  = b_lat[15:0];
                addend = {32'd0, pp};
            end
            S10: begin
                mul_x  = a_lat[31:16];
                mul_y  = b_lat[15:0];
                addend = {16'd0, pp, 16'd0};
            end
            S01: begin
                mul_x  = a_lat[15:0];
                mul_y  = b_lat[31:16];
                addend = {16'd0, pp, 16'd0};
            end
            S11: begin
                mul_x  = a_lat[31:16];
                mul_y  = b_lat[31:16];
                addend = {pp, 32'd0};
            end
            default: begin
                mul_x  = '0;
                mul_y  = '0;
                addend = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            a_lat   <= '0;
            b_lat   <= '0;
            product <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE) begin
                if (start) begin
                    a_lat   <= a;
                    b_lat   <= b;
                    product <= '0;
                end
            end else begin
                product <= product + addend;
            end
        end
    end

endmodule

// File: tb/tb_mult_32x32_fast.sv
// tb_mult_32x32_fast
//   Self-checking bench for mult_32x32_fast: reset behaviour, a table of
//   directed operations, multi-cycle corner sequences (operand changes and
//   extra start while busy, reset mid-operation, start held high) and random
//   operations compared against a plain-arithmetic reference model.
module tb_mult_32x32_fast;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [63:0] product;

    int unsigned vectors;
    int unsigned miscompares;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] prod;
        int unsigned lat;
    } vec_t;

    vec_t vecs[6];

    mult_32x32_fast dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    // Latency implied by the skip rules: S00 always, S10 if a1!=0, S01 if b1!=0,
    // S11 if both are nonzero.
    function automatic int unsigned model_lat(input logic [31:0] av, input logic [31:0] bv);
        int unsigned n;
        n = 1;
        if (av[31:16] != 16'd0) n++;
        if (bv[31:16] != 16'd0) n++;
        if (av[31:16] != 16'd0 && bv[31:16] != 16'd0) n++;
        return n;
    endfunction

    function automatic logic [63:0] model_prod(input logic [31:0] av, input logic [31:0] bv);
        logic [63:0] x;
        logic [63:0] y;
        x = {32'd0, av};
        y = {32'd0, bv};
        return x * y;
    endfunction

    // Issue a one-cycle start pulse and wait (bounded) for busy to fall.
    task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                          output int unsigned lat, output logic [63:0] res,
                          output logic cleared);
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        cleared = busy && (product == 64'd0);
        lat     = 0;
        while (busy && lat < 16) begin
            lat++;
            @(negedge clk);
        end
        res = product;
    endtask

    initial begin
        int unsigned lat;
        logic [63:0] res;
        logic        cleared;
        logic [31:0] ra;
        logic [31:0] rb;
        int unsigned sel;

        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        start       = 1'b0;
        a           = '0;
        b           = '0;

        vecs[0] = '{a: 32'h1272E0E1, b: 32'h12DA00DB, prod: 64'd97893587989061755, lat: 4};
        vecs[1] = '{a: 32'h0000E0E1, b: 32'h000000DB, prod: 64'd12607611,          lat: 1};
        vecs[2] = '{a: 32'h1272E0E1, b: 32'h000000DB, prod: 64'd67784564859,       lat: 2};
        vecs[3] = '{a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, prod: 64'hFFFFFFFE00000001,  lat: 4};
        vecs[4] = '{a: 32'h00000003, b: 32'h00050002, prod: 64'h00000000000F0006,  lat: 2};
        vecs[5] = '{a: 32'h00000000, b: 32'h00000000, prod: 64'd0,                 lat: 1};

        // Reset held for 4 cycles, then released: stays idle with a zero product.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("reset_busy", {63'd0, busy}, 64'd0);
            check("reset_product", product, 64'd0);
        end
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("idle_busy", {63'd0, busy}, 64'd0);
            check("idle_product", product, 64'd0);
        end

        // Directed table.
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, lat, res, cleared);
            check("tbl_cleared_at_accept", {63'd0, cleared}, 64'd1);
            check("tbl_latency", 64'(lat), 64'(vecs[i].lat));
            check("tbl_product", res, vecs[i].prod);
            repeat (2) @(negedge clk);
            check("tbl_product_held", product, vecs[i].prod);
        end

        // Operands change and start pulses while busy: original operands are used.
        @(negedge clk);
        a     = 32'h1272E0E1;
        b     = 32'h12DA00DB;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = 32'hFFFFFFFF;
        b     = 32'h00000001;
        lat   = 0;
        while (busy && lat < 16) begin
            lat++;
            if (lat == 2) start = 1'b1;
            else start = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        check("rob_latency", 64'(lat), 64'd4);
        check("rob_product", product, 64'd97893587989061755);
        @(negedge clk);
        check("rob_extra_start_ignored", {63'd0, busy}, 64'd0);

        // Reset asserted during S10 aborts the operation.
        @(negedge clk);
        a     = 32'h1272E0E1;
        b     = 32'h12DA00DB;
        start = 1'b1;
        @(negedge clk);            // in S00
        start = 1'b0;
        @(negedge clk);            // in S10
        check("abort_busy_before", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_product", product, 64'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_no_completion", {63'd0, busy}, 64'd0);
        check("abort_product_stays", product, 64'd0);

        // start held high: 1-cycle operations alternate with one idle cycle.
        @(negedge clk);
        a     = 32'd5;
        b     = 32'd7;
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_busy_op", {63'd0, busy}, 64'd1);
            check("hold_product_cleared", product, 64'd0);
            @(negedge clk);
            check("hold_busy_gap", {63'd0, busy}, 64'd0);
            check("hold_product", product, 64'd35);
        end
        start = 1'b0;
        repeat (2) @(negedge clk);

        // Random operations against the reference model.
        for (int i = 0; i < 200; i++) begin
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 3);
            if (sel[0]) ra[31:16] = 16'd0;
            if (sel[1]) rb[31:16] = 16'd0;
            run_op(ra, rb, lat, res, cleared);
            check("rnd_cleared_at_accept", {63'd0, cleared}, 64'd1);
            check("rnd_latency", 64'(lat), 64'(model_lat(ra, rb)));
            check("rnd_product", res, model_prod(ra, rb));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
